// File: rtl/period_lock_pkg.sv
// Shared types and helpers for the period lock-detection controller.
// Holds the FSM state encoding and the tolerance comparator function.
package period_lock_pkg;

    localparam int STATE_W = 2;
    localparam int DIFF_W  = 33;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 2'd0,
        ST_CLEAR   = 2'd1,
        ST_ACQUIRE = 2'd2,
        ST_LOCKED  = 2'd3
    } lock_state_e;

    // Absolute difference in one extra bit so large operands never wrap.
    function automatic logic [DIFF_W-1:0] abs_diff(
        input logic [31:0] a,
        input logic [31:0] b
    );
        logic [DIFF_W-1:0] a_ext;
        logic [DIFF_W-1:0] b_ext;
        logic [DIFF_W-1:0] diff;
        a_ext = {1'b0, a};
        b_ext = {1'b0, b};
        if (a_ext >= b_ext) begin
            diff = a_ext - b_ext;
        end else begin
            diff = b_ext - a_ext;
        end
        return diff;
    endfunction

    // A zero period means the measurement has not produced a result yet.
    function automatic logic period_match(
        input logic [31:0] period,
        input logic [31:0] target,
        input logic [31:0] tol
    );
        logic result;
        if (period == 32'd0) begin
            result = 1'b0;
        end else if (abs_diff(period, target) <= {1'b0, tol}) begin
            result = 1'b1;
        end else begin
            result = 1'b0;
        end
        return result;
    endfunction

endpackage

// File: rtl/period_lock_tick.sv
// Free-running sample interval counter producing a registered one-cycle
// tick every SAMPLE_CYCLES enabled clocks; synchronous clear restarts it.
module period_lock_tick #(
    parameter int SAMPLE_CYCLES = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic srst,
    output logic tick
);

    localparam int CNT_W = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             tick_r;

    // Next counter value: clear wins, otherwise count and wrap while enabled.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (srst) begin
            cnt_nxt_s = {CNT_W{1'b0}};
        end else if (en) begin
            if (cnt_r == CNT_LAST) begin
                cnt_nxt_s = {CNT_W{1'b0}};
            end else begin
                cnt_nxt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Counter and tick registers; tick is high while the count sits at its last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r  <= {CNT_W{1'b0}};
            tick_r <= 1'b0;
        end else begin
            cnt_r  <= cnt_nxt_s;
            tick_r <= (cnt_nxt_s == CNT_LAST);
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/period_lock_ctrl.sv
// Lock-detection controller sequencing the period_count block of the PLL model.
// Define PERIOD_LOCK_STATS_EN to add the saturating lock_loss_cnt output.
module period_lock_ctrl
    import period_lock_pkg::*;
#(
    parameter int SAMPLE_CYCLES = 64,
    parameter int LOCK_COUNT    = 4,
    parameter int UNLOCK_COUNT  = 2,
    parameter int RST_CYCLES    = 2
) (
    input  logic               clk,
    input  logic               RST_N,
    input  logic               PWRDWN,
    input  logic [31:0]        period_length_1000,
    input  logic [31:0]        target_1000,
    input  logic [31:0]        tol_1000,
    output logic               count_rst,
    output logic               LOCKED,
    output logic [STATE_W-1:0] state
`ifdef PERIOD_LOCK_STATS_EN
    ,
    output logic [15:0]        lock_loss_cnt
`endif
);

    localparam int HIT_W  = $clog2(LOCK_COUNT + 1);
    localparam int MISS_W = $clog2(UNLOCK_COUNT + 1);
    localparam int CLR_W  = $clog2(RST_CYCLES + 1);
    localparam logic [HIT_W-1:0]  HIT_LAST  = HIT_W'(LOCK_COUNT - 1);
    localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(UNLOCK_COUNT - 1);
    localparam logic [CLR_W-1:0]  CLR_LAST  = CLR_W'(RST_CYCLES - 1);

    lock_state_e       state_r;
    logic [HIT_W-1:0]  hit_r;
    logic [MISS_W-1:0] miss_r;
    logic [CLR_W-1:0]  clr_r;
    logic              locked_r;
    logic              count_rst_r;

    logic tick_s;
    logic tick_en_s;
    logic tick_srst_s;
    logic match_s;
    logic acq_tick_s;
    logic lock_tick_s;
    logic lock_evt_s;
    logic unlock_evt_s;

    // Sample counter only runs while acquiring or locked; power-down clears it.
    always_comb begin
        tick_en_s   = 1'b0;
        tick_srst_s = 1'b1;
        if ((state_r == ST_ACQUIRE) || (state_r == ST_LOCKED)) begin
            tick_en_s   = 1'b1;
            tick_srst_s = PWRDWN;
        end else begin
            tick_en_s   = 1'b0;
            tick_srst_s = 1'b1;
        end
    end

    period_lock_tick #(
        .SAMPLE_CYCLES (SAMPLE_CYCLES)
    ) u_tick (
        .clk   (clk),
        .rst_n (RST_N),
        .en    (tick_en_s),
        .srst  (tick_srst_s),
        .tick  (tick_s)
    );

    // Comparator and the qualified tick events; power-down masks every tick.
    always_comb begin
        match_s      = period_match(period_length_1000, target_1000, tol_1000);
        acq_tick_s   = 1'b0;
        lock_tick_s  = 1'b0;
        lock_evt_s   = 1'b0;
        unlock_evt_s = 1'b0;
        if (tick_s && !PWRDWN) begin
            acq_tick_s   = (state_r == ST_ACQUIRE);
            lock_tick_s  = (state_r == ST_LOCKED);
            lock_evt_s   = acq_tick_s && match_s && (hit_r == HIT_LAST);
            unlock_evt_s = lock_tick_s && !match_s && (miss_r == MISS_LAST);
        end else begin
            acq_tick_s   = 1'b0;
            lock_tick_s  = 1'b0;
            lock_evt_s   = 1'b0;
            unlock_evt_s = 1'b0;
        end
    end

    // Main FSM with hit/miss/clear counters and registered outputs.
    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            state_r     <= ST_IDLE;
            hit_r       <= {HIT_W{1'b0}};
            miss_r      <= {MISS_W{1'b0}};
            clr_r       <= {CLR_W{1'b0}};
            locked_r    <= 1'b0;
            count_rst_r <= 1'b1;
        end else if (PWRDWN) begin
            state_r     <= ST_IDLE;
            hit_r       <= {HIT_W{1'b0}};
            miss_r      <= {MISS_W{1'b0}};
            clr_r       <= {CLR_W{1'b0}};
            locked_r    <= 1'b0;
            count_rst_r <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_r     <= ST_CLEAR;
                    hit_r       <= {HIT_W{1'b0}};
                    miss_r      <= {MISS_W{1'b0}};
                    clr_r       <= {CLR_W{1'b0}};
                    locked_r    <= 1'b0;
                    count_rst_r <= 1'b1;
                end
                ST_CLEAR: begin
                    if (clr_r == CLR_LAST) begin
                        state_r     <= ST_ACQUIRE;
                        clr_r       <= {CLR_W{1'b0}};
                        count_rst_r <= 1'b0;
                    end else begin
                        clr_r       <= clr_r + {{(CLR_W-1){1'b0}}, 1'b1};
                        count_rst_r <= 1'b1;
                    end
                end
                ST_ACQUIRE: begin
                    if (lock_evt_s) begin
                        state_r  <= ST_LOCKED;
                        hit_r    <= {HIT_W{1'b0}};
                        miss_r   <= {MISS_W{1'b0}};
                        locked_r <= 1'b1;
                    end else if (acq_tick_s && match_s) begin
                        hit_r <= hit_r + {{(HIT_W-1){1'b0}}, 1'b1};
                    end else if (acq_tick_s) begin
                        hit_r <= {HIT_W{1'b0}};
                    end else begin
                        hit_r <= hit_r;
                    end
                end
                ST_LOCKED: begin
                    // Losing lock restarts the whole acquisition, including the counter reset.
                    if (unlock_evt_s) begin
                        state_r     <= ST_CLEAR;
                        hit_r       <= {HIT_W{1'b0}};
                        miss_r      <= {MISS_W{1'b0}};
                        clr_r       <= {CLR_W{1'b0}};
                        locked_r    <= 1'b0;
                        count_rst_r <= 1'b1;
                    end else if (lock_tick_s && !match_s) begin
                        miss_r <= miss_r + {{(MISS_W-1){1'b0}}, 1'b1};
                    end else if (lock_tick_s) begin
                        miss_r <= {MISS_W{1'b0}};
                    end else begin
                        miss_r <= miss_r;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    hit_r       <= {HIT_W{1'b0}};
                    miss_r      <= {MISS_W{1'b0}};
                    clr_r       <= {CLR_W{1'b0}};
                    locked_r    <= 1'b0;
                    count_rst_r <= 1'b1;
                end
            endcase
        end
    end

    assign state     = state_r;
    assign LOCKED    = locked_r;
    assign count_rst = count_rst_r;

`ifdef PERIOD_LOCK_STATS_EN
    logic [15:0] loss_cnt_r;

    // Saturating count of lock losses; survives power-down, cleared only by reset.
    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            loss_cnt_r <= 16'd0;
        end else if (unlock_evt_s && (loss_cnt_r != 16'hFFFF)) begin
            loss_cnt_r <= loss_cnt_r + 16'd1;
        end else begin
            loss_cnt_r <= loss_cnt_r;
        end
    end

    assign lock_loss_cnt = loss_cnt_r;
`endif

endmodule

// File: tb/tb_period_lock_ctrl.sv
// Self-checking bench for period_lock_ctrl: directed scenarios plus random
// sample streams checked against a per-sample behavioural lock model.
module tb_period_lock_ctrl;

    localparam int SAMPLE_CYCLES = 64;
    localparam int LOCK_COUNT    = 4;
    localparam int UNLOCK_COUNT  = 2;
    localparam int RST_CYCLES    = 2;

    logic        clk = 1'b0;
    logic        RST_N;
    logic        PWRDWN;
    logic [31:0] period_length_1000;
    logic [31:0] target_1000;
    logic [31:0] tol_1000;
    logic        count_rst;
    logic        LOCKED;
    logic [1:0]  state;
`ifdef PERIOD_LOCK_STATS_EN
    logic [15:0] lock_loss_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: lock flag, length of current match/miss run, loss count.
    bit m_locked;
    int m_run;
    int m_losses;

    always #5 clk = ~clk;

    period_lock_ctrl #(
        .SAMPLE_CYCLES (SAMPLE_CYCLES),
        .LOCK_COUNT    (LOCK_COUNT),
        .UNLOCK_COUNT  (UNLOCK_COUNT),
        .RST_CYCLES    (RST_CYCLES)
    ) dut (
        .clk                (clk),
        .RST_N              (RST_N),
        .PWRDWN             (PWRDWN),
        .period_length_1000 (period_length_1000),
        .target_1000        (target_1000),
        .tol_1000           (tol_1000),
        .count_rst          (count_rst),
        .LOCKED             (LOCKED),
        .state              (state)
`ifdef PERIOD_LOCK_STATS_EN
        ,
        .lock_loss_cnt      (lock_loss_cnt)
`endif
    );

    function automatic bit ref_match(input logic [31:0] p, input logic [31:0] t, input logic [31:0] tl);
        longint d;
        if (p == 32'd0) return 1'b0;
        d = longint'({32'd0, p}) - longint'({32'd0, t});
        if (d < 0) d = -d;
        return (d <= longint'({32'd0, tl}));
    endfunction

    function automatic logic [1:0] run_state();
        return m_locked ? 2'd3 : 2'd2;
    endfunction

    function automatic logic [31:0] rand_period();
        if ($urandom_range(0, 3) != 0) return 32'($urandom_range(9900, 10100));
        if ($urandom_range(0, 1) != 0) return 32'($urandom_range(10101, 11000));
        return 32'($urandom_range(9000, 9899));
    endfunction

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input bit e_locked, input bit e_crst, input logic [1:0] e_state);
        check({tag, ".LOCKED"}, 32'(LOCKED), 32'(e_locked));
        check({tag, ".count_rst"}, 32'(count_rst), 32'(e_crst));
        check({tag, ".state"}, 32'(state), 32'(e_state));
    endtask

    task automatic check_loss(input string tag);
`ifdef PERIOD_LOCK_STATS_EN
        check({tag, ".lock_loss_cnt"}, 32'(lock_loss_cnt), 32'(m_losses));
`else
        n_checks = n_checks + 0;
`endif
    endtask

    // Called right after the edge that entered CLEAR: finish the clear window.
    task automatic clear_rest(input string tag);
        wait_edges(RST_CYCLES - 1);
        check_outs({tag, ".clear"}, 1'b0, 1'b1, 2'd1);
        wait_edges(1);
        check_outs({tag, ".acquire"}, 1'b0, 1'b0, 2'd2);
        m_locked = 1'b0;
        m_run    = 0;
    endtask

    // One full sample interval with period p, then the model's verdict.
    task automatic do_tick(input string tag, input logic [31:0] p);
        bit is_match;
        period_length_1000 = p;
        wait_edges(SAMPLE_CYCLES - 1);
        check_outs({tag, ".pre"}, m_locked, 1'b0, run_state());
        wait_edges(1);
        is_match = ref_match(p, target_1000, tol_1000);
        if (!m_locked) begin
            m_run = is_match ? m_run + 1 : 0;
            if (m_run == LOCK_COUNT) begin
                m_locked = 1'b1;
                m_run    = 0;
            end
            check_outs(tag, m_locked, 1'b0, run_state());
        end else begin
            m_run = is_match ? 0 : m_run + 1;
            if (m_run == UNLOCK_COUNT) begin
                m_locked = 1'b0;
                m_run    = 0;
                if (m_losses < 65535) m_losses++;
                check_outs({tag, ".unlock"}, 1'b0, 1'b1, 2'd1);
                check_loss(tag);
                clear_rest(tag);
            end else begin
                check_outs(tag, 1'b1, 1'b0, 2'd3);
            end
        end
    endtask

    initial begin
        RST_N = 1'b0;
        PWRDWN = 1'b0;
        target_1000 = 32'd10000;
        tol_1000 = 32'd100;
        period_length_1000 = 32'd10050;
        m_locked = 1'b0;
        m_run = 0;
        m_losses = 0;

        wait_edges(3);
        check_outs("reset", 1'b0, 1'b1, 2'd0);
        check_loss("reset");

        PWRDWN = 1'b1;
        RST_N = 1'b1;
        wait_edges(4);
        check_outs("pwrdwn_hold", 1'b0, 1'b1, 2'd0);

        PWRDWN = 1'b0;
        wait_edges(1);
        check_outs("edge1", 1'b0, 1'b1, 2'd1);
        clear_rest("startup");

        for (int i = 0; i < LOCK_COUNT; i++) do_tick("nominal", 32'd10050);
        check("nominal.locked_model", 32'(LOCKED), 32'd1);

        do_tick("loss_single", 32'd9800);
        do_tick("loss_recover", 32'd10000);
        do_tick("loss_a", 32'd9800);
        do_tick("loss_b", 32'd9800);

        for (int i = 0; i < 3; i++) do_tick("reject_hit", 32'd10050);
        do_tick("reject_miss", 32'd10200);
        for (int i = 0; i < LOCK_COUNT; i++) do_tick("reject_relock", 32'd10050);

        do_tick("bound_hi", 32'd10100);
        do_tick("bound_over", 32'd10101);
        do_tick("bound_lo", 32'd9900);

        for (int i = 0; i < 40; i++) do_tick("random", rand_period());

        for (int k = 0; k < 12 && !m_locked; k++) do_tick("relock", 32'd10000);

        // Power-down pulse landing exactly on a matching tick edge.
        period_length_1000 = 32'd10000;
        wait_edges(SAMPLE_CYCLES - 1);
        PWRDWN = 1'b1;
        wait_edges(1);
        check_outs("pwrdwn_tick", 1'b0, 1'b1, 2'd0);
        check_loss("pwrdwn_tick");
        PWRDWN = 1'b0;
        wait_edges(1);
        check_outs("pwrdwn_edge1", 1'b0, 1'b1, 2'd1);
        clear_rest("pwrdwn");
        for (int i = 0; i < LOCK_COUNT; i++) do_tick("pwrdwn_relock", 32'd10050);

        target_1000 = 32'd0;
        for (int i = 0; i < UNLOCK_COUNT + 5; i++) do_tick("zero_period", 32'd0);
        do_tick("max_period", 32'hFFFFFFFF);
        do_tick("max_period", 32'hFFFFFFFF);
        target_1000 = 32'hFFFFFFFF;
        do_tick("wrap_guard", 32'd1);
        do_tick("wrap_guard", 32'd1);
        target_1000 = 32'd10000;

        do_tick("pre_rst", 32'd10050);
        wait_edges(20);
        RST_N = 1'b0;
        #1;
        check_outs("async_rst", 1'b0, 1'b1, 2'd0);
        m_locked = 1'b0;
        m_run = 0;
        m_losses = 0;
        check_loss("async_rst");
        wait_edges(2);
        check_outs("rst_held", 1'b0, 1'b1, 2'd0);
        RST_N = 1'b1;
        wait_edges(1);
        check_outs("rst_edge1", 1'b0, 1'b1, 2'd1);
        clear_rest("post_rst");
        for (int i = 0; i < LOCK_COUNT; i++) do_tick("post_rst_lock", 32'd10050);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
